// File: rtl/mem_stage.sv
// MIPS memory-access stage: pass-through, aligned loads/stores, LL/SC link tracking, one writeback beat per op.
// Optional MEM_ALIGN_CHECK_EN turns misaligned half/word accesses into single-cycle exception beats.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_dest,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        mem_exc
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_LL  = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd7;
  localparam logic [3:0] OP_SH  = 4'd8;
  localparam logic [3:0] OP_SW  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [4:0]  dest_q;
  logic        link_valid;
  logic [29:0] link_addr;

  logic        accept, start_mem, misaligned, sc_ok;
  logic        is_load, is_store, is_sc, sz_byte, sz_half, sz_word;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;

  // Decode of the incoming operation
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_sc    = 1'b0;
    sz_byte  = 1'b0;
    sz_half  = 1'b0;
    sz_word  = 1'b0;
    case (ex_mem_op)
      OP_LB, OP_LBU: begin is_load  = 1'b1; sz_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
      OP_LW, OP_LL:  begin is_load  = 1'b1; sz_word = 1'b1; end
      OP_SB:         begin is_store = 1'b1; sz_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; sz_word = 1'b1; end
      OP_SC:         begin is_sc    = 1'b1; sz_word = 1'b1; end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (sz_half & ex_addr[0]) | (sz_word & (ex_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign accept    = ex_valid & (state == IDLE);
  assign sc_ok     = link_valid & (ex_addr[31:2] == link_addr);
  assign start_mem = accept & ~misaligned & (is_load | is_store | (is_sc & sc_ok));

  // Byte-lane enables and lane-replicated write data
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = ex_store_data;
    if (sz_byte) begin
      be_nxt    = 4'b0001 << ex_addr[1:0];
      wdata_nxt = {4{ex_store_data[7:0]}};
    end else if (sz_half) begin
      be_nxt    = ex_addr[1] ? 4'b1100 : 4'b0011;
      wdata_nxt = {2{ex_store_data[15:0]}};
    end
  end

  // Load lane extraction and extension
  always_comb begin
    rd_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
    rd_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q)
      OP_LB:   ld_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  ld_data = {24'd0, rd_byte};
      OP_LH:   ld_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  ld_data = {16'd0, rd_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_mem) state_nxt = BUSY;
      BUSY:    if (dmem_ack)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ex_ready = (state == IDLE);
  assign dmem_req = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 4'd0;
      lane_q     <= 2'd0;
      dest_q     <= 5'd0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_dest    <= 5'd0;
      wb_data    <= 32'd0;
      mem_exc    <= 1'b0;
      link_valid <= 1'b0;
      link_addr  <= 30'd0;
    end else begin
      wb_valid <= 1'b0;
      if (start_mem) begin
        op_q       <= ex_mem_op;
        lane_q     <= ex_addr[1:0];
        dest_q     <= ex_dest;
        dmem_we    <= is_store | is_sc;
        dmem_addr  <= {ex_addr[31:2], 2'b00};
        dmem_be    <= be_nxt;
        dmem_wdata <= wdata_nxt;
      end else if (accept) begin
        // Completes without touching memory: pass-through, failed SC or misalignment
        wb_valid <= 1'b1;
        wb_dest  <= ex_dest;
        wb_we    <= ~misaligned;
        mem_exc  <= misaligned;
        wb_data  <= (misaligned | is_sc) ? 32'd0 : ex_addr;
        if (is_sc & ~misaligned) link_valid <= 1'b0;
      end else if ((state == BUSY) && dmem_ack) begin
        wb_valid <= 1'b1;
        wb_dest  <= dest_q;
        mem_exc  <= 1'b0;
        wb_we    <= ~((op_q == OP_SB) | (op_q == OP_SH) | (op_q == OP_SW));
        case (op_q)
          OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL: wb_data <= ld_data;
          OP_SC:   wb_data <= 32'd1;
          default: wb_data <= 32'd0;
        endcase
        if (op_q == OP_LL) begin
          link_valid <= 1'b1;
          link_addr  <= dmem_addr[31:2];
        end
        if (op_q == OP_SC) link_valid <= 1'b0;
        if (((op_q == OP_SB) | (op_q == OP_SH) | (op_q == OP_SW)) && (dmem_addr[31:2] == link_addr))
          link_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then random ops against a behavioural model.
module tb_mem_stage;

  localparam logic [3:0] LB = 1, LBU = 2, LH = 3, LHU = 4, LW = 5, LL = 6,
                         SB = 7, SH = 8, SW = 9, SC = 10;

  logic        clk, rst;
  logic        ex_valid, ex_ready;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_addr, ex_store_data;
  logic [4:0]  ex_dest;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we, mem_exc;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem_op(ex_mem_op), .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data), .mem_exc(mem_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] dest; logic we; logic exc; logic [31:0] data; logic mem; } wb_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;

  wb_t         exp_wb[$];
  req_t        exp_req[$];
  logic [31:0] mmem[8];
  logic [31:0] rmem[8];
  logic        link_v;
  logic [29:0] link_a;
  int          total = 0;
  int          bad = 0;
  int          fixed_lat = 0;
  bit          hold_ack = 0;
  bit          stray_ack = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each accepted op is resolved immediately from the architectural rules
  task automatic model_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                              input logic [4:0] d);
    wb_t w; req_t r; logic [31:0] word, v; int idx, lane; bit mis, wr;
    idx = int'(a[4:2]); lane = int'(a[1:0]); word = mmem[idx];
    w.dest = d; w.we = 1; w.exc = 0; w.data = 0; w.mem = 0;
    r.addr = {a[31:2], 2'b00}; r.we = 0; r.be = 0; r.wdata = 0;
    mis = 0; wr = 0;
`ifdef MEM_ALIGN_CHECK_EN
    if ((op == LH || op == LHU || op == SH) && a[0]) mis = 1;
    if ((op == LW || op == LL || op == SW || op == SC) && a[1:0] != 2'b00) mis = 1;
`endif
    if (mis) begin
      w.we = 0; w.exc = 1;
    end else begin
      case (op)
        LB, LBU: begin
          v = (word >> (8 * lane)) & 32'hFF;
          if (op == LB && v >= 128) v = v | 32'hFFFF_FF00;
          w.data = v; w.mem = 1;
        end
        LH, LHU: begin
          v = a[1] ? (word >> 16) : (word & 32'hFFFF);
          if (op == LH && v >= 32768) v = v | 32'hFFFF_0000;
          w.data = v; w.mem = 1;
        end
        LW, LL: begin
          w.data = word; w.mem = 1;
          if (op == LL) begin link_v = 1; link_a = a[31:2]; end
        end
        SB: begin wr = 1; r.be = 4'(1 << lane); r.wdata = (sd & 32'hFF) * 32'h0101_0101; end
        SH: begin wr = 1; r.be = a[1] ? 4'hC : 4'h3; r.wdata = (sd & 32'hFFFF) * 32'h0001_0001; end
        SW: begin wr = 1; r.be = 4'hF; r.wdata = sd; end
        SC: begin
          if (link_v && link_a == a[31:2]) begin
            wr = 1; r.be = 4'hF; r.wdata = sd; w.data = 1;
          end
          link_v = 0;
        end
        default: w.data = a;
      endcase
      if (wr) begin
        r.we = 1; w.mem = 1;
        if (op != SC) begin
          w.we = 0;
          if (link_v && link_a == a[31:2]) link_v = 0;
        end
        for (int k = 0; k < 4; k++)
          if (r.be[k]) word[8*k +: 8] = r.wdata[8*k +: 8];
        mmem[idx] = word;
      end
      if (w.mem) exp_req.push_back(r);
    end
    exp_wb.push_back(w);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                      input logic [4:0] d);
    int n = 0;
    while (!ex_ready && n < 100) begin @(negedge clk); n++; end
    if (!ex_ready) chk("send_timeout", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1; ex_mem_op = op; ex_addr = a; ex_store_data = sd; ex_dest = d;
    model_accept(op, a, sd, d);
    @(negedge clk);
    ex_valid = 0;
  endtask

  task automatic wait_wb(output int cyc, output bit rdy_seen);
    cyc = 0; rdy_seen = 0;
    while (!wb_valid && cyc < 50) begin
      if (ex_ready) rdy_seen = 1;
      @(negedge clk); cyc++;
    end
    chk("wb_timeout", {31'd0, wb_valid}, 32'd1);
  endtask

  // Memory responder: random or fixed latency, can withhold ack or pulse a stray ack
  int lat = 0;
  initial begin
    dmem_ack = 0; dmem_rdata = 0;
    forever begin
      @(negedge clk);
      dmem_ack = 0;
      if (stray_ack) begin
        dmem_ack = 1;
      end else if (dmem_req && !hold_ack) begin
        if (lat == 0) lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
        lat--;
        if (lat == 0) begin
          dmem_ack = 1;
          dmem_rdata = rmem[dmem_addr[4:2]];
          if (dmem_we)
            for (int k = 0; k < 4; k++)
              if (dmem_be[k]) rmem[dmem_addr[4:2]][8*k +: 8] = dmem_wdata[8*k +: 8];
        end
      end
    end
  end

  // Every-cycle comparison against the model queues
  initial begin
    wb_t w; req_t r;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        chk("ready_vs_req", {31'd0, ex_ready}, {31'd0, ~dmem_req});
        if (dmem_req) begin
          if (exp_req.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
          else begin
            r = exp_req[0];
            chk("req_addr", dmem_addr, r.addr);
            chk("req_we", {31'd0, dmem_we}, {31'd0, r.we});
            if (r.we) begin
              chk("req_be", {28'd0, dmem_be}, {28'd0, r.be});
              chk("req_wdata", dmem_wdata, r.wdata);
            end
          end
        end
        if (wb_valid) begin
          if (exp_wb.size() == 0) chk("unexpected_wb", 32'd1, 32'd0);
          else begin
            w = exp_wb.pop_front();
            if (w.mem && exp_req.size() != 0) void'(exp_req.pop_front());
            chk("wb_dest", {27'd0, wb_dest}, {27'd0, w.dest});
            chk("wb_we", {31'd0, wb_we}, {31'd0, w.we});
            chk("mem_exc", {31'd0, mem_exc}, {31'd0, w.exc});
            if (w.we) chk("wb_data", wb_data, w.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc; bit rs; int n;
    logic [3:0] op; logic [31:0] a;
    rst = 1; ex_valid = 0; ex_mem_op = 0; ex_addr = 0; ex_store_data = 0; ex_dest = 0;
    link_v = 0; link_a = 0;
    for (int i = 0; i < 8; i++) begin mmem[i] = $urandom; rmem[i] = mmem[i]; end
    mmem[0] = 32'h80FF_0000; rmem[0] = 32'h80FF_0000;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_wb_dest", {27'd0, wb_dest}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_exc", {31'd0, mem_exc}, 32'd0);
    rst = 0;

    send(4'd0, 32'h1234_5678, 32'd0, 5'd5);
    chk("none_valid", {31'd0, wb_valid}, 32'd1);
    chk("none_data", wb_data, 32'h1234_5678);
    chk("none_we", {31'd0, wb_we}, 32'd1);
    chk("none_req", {31'd0, dmem_req}, 32'd0);

    fixed_lat = 3;
    send(LB, 32'h103, 32'd0, 5'd7);
    chk("lb_addr", dmem_addr, 32'h100);
    wait_wb(cyc, rs);
    chk("lb_cycles", cyc, 3);
    chk("lb_ready_low", {31'd0, rs}, 32'd0);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_ready_back", {31'd0, ex_ready}, 32'd1);
    send(LBU, 32'h103, 32'd0, 5'd8);
    wait_wb(cyc, rs);
    chk("lbu_ready_low", {31'd0, rs}, 32'd0);
    chk("lbu_data", wb_data, 32'h0000_0080);

    fixed_lat = 1;
    send(SH, 32'h202, 32'h0000_ABCD, 5'd9);
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", {31'd0, dmem_we}, 32'd1);
    wait_wb(cyc, rs);
    chk("sh_wb_we", {31'd0, wb_we}, 32'd0);

    send(LL, 32'h300, 32'd0, 5'd10); wait_wb(cyc, rs);
    send(SC, 32'h300, 32'hCAFE_F00D, 5'd11);
    chk("sc_ok_req", {31'd0, dmem_req}, 32'd1);
    wait_wb(cyc, rs);
    chk("sc_ok_data", wb_data, 32'd1);
    send(SC, 32'h300, 32'h1111_2222, 5'd12);
    chk("sc2_req", {31'd0, dmem_req}, 32'd0);
    chk("sc2_valid", {31'd0, wb_valid}, 32'd1);
    chk("sc2_data", wb_data, 32'd0);
    send(LL, 32'h300, 32'd0, 5'd10); wait_wb(cyc, rs);
    send(SW, 32'h300, 32'h5555_AAAA, 5'd0); wait_wb(cyc, rs);
    send(SC, 32'h300, 32'h3333_4444, 5'd13);
    chk("sc3_req", {31'd0, dmem_req}, 32'd0);
    chk("sc3_data", wb_data, 32'd0);

    hold_ack = 1;
    send(LW, 32'h10, 32'd0, 5'd3);
    chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    rst = 1; #1;
    chk("rst_busy_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_busy_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_busy_wb", {31'd0, wb_valid}, 32'd0);
    exp_wb.delete(); exp_req.delete(); link_v = 0;
    @(negedge clk);
    rst = 0; hold_ack = 0;
    #2 stray_ack = 1;
    @(negedge clk); #2 stray_ack = 0;
    repeat (2) begin
      @(negedge clk);
      chk("stray_wb", {31'd0, wb_valid}, 32'd0);
      chk("stray_req", {31'd0, dmem_req}, 32'd0);
      chk("stray_ready", {31'd0, ex_ready}, 32'd1);
    end

    send(LW, 32'h402, 32'd0, 5'd14);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_exc", {31'd0, mem_exc}, 32'd1);
    chk("mis_we", {31'd0, wb_we}, 32'd0);
`else
    chk("lw_unal_addr", dmem_addr, 32'h400);
    wait_wb(cyc, rs);
    chk("lw_unal_we", {31'd0, wb_we}, 32'd1);
    chk("lw_unal_exc", {31'd0, mem_exc}, 32'd0);
`endif

    fixed_lat = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      op = 4'($urandom_range(0, 15));
      if (op >= 1 && op <= 10) a = 32'($urandom_range(0, 31));
      else a = $urandom;
      if (op == SC && link_v && $urandom_range(0, 1) == 1) a = {link_a, 2'b00};
      send(op, a, $urandom, 5'($urandom_range(0, 31)));
    end
    n = 0;
    while (exp_wb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", exp_wb.size(), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
